// File: rtl/tpu_host_pkg.sv
// Shared types and constants for the 2x2 TPU host driver.
// States, pin bit positions and parameter defaults.
package tpu_host_pkg;

  localparam int N_OPERAND_DEF = 8;
  localparam int N_RESULT_DEF  = 4;
  localparam int TIMEOUT_DEF   = 64;

  localparam int UIO_LOAD_EN    = 0;
  localparam int UIO_TRANSPOSE  = 1;
  localparam int UIO_ACTIVATION = 2;
  localparam int UIO_DONE       = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CAPTURE,
    RESP
  } state_e;

endpackage

// File: rtl/tpu_host_driver_capture.sv
// Result byte capture for the TPU host driver.
// Shifts in result bytes while done is high, flags short bursts.
module tpu_result_capture
  import tpu_host_pkg::*;
#(
  parameter int N_RESULT = N_RESULT_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic                  done_i,
  input  logic [7:0]            byte_i,
  output logic [8*N_RESULT-1:0] data_o,
  output logic                  last_o,
  output logic                  short_o
);

  localparam int RW = $clog2(N_RESULT);

  logic [RW-1:0]         ridx_q, ridx_d;
  logic [8*N_RESULT-1:0] data_q, data_d;

  // ridx != 0 means a burst has started, so a low done is a short burst
  always_comb begin
    ridx_d  = ridx_q;
    data_d  = data_q;
    last_o  = en_i & done_i & (ridx_q == RW'(N_RESULT - 1));
    short_o = en_i & ~done_i & (ridx_q != '0);
    if (clr_i) begin
      ridx_d = '0;
      data_d = '0;
    end else if (en_i & done_i) begin
      data_d[8*ridx_q +: 8] = byte_i;
      if (!last_o) begin
        ridx_d = ridx_q + 1'b1;
      end
    end
  end

  // capture state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ridx_q <= '0;
      data_q <= '0;
    end else begin
      ridx_q <= ridx_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/tpu_host_driver.sv
// Host-side initiator for the 2x2 matmul accelerator pins.
// Loads operands, waits for done, captures and returns results.
module tpu_host_driver
  import tpu_host_pkg::*;
#(
  parameter int N_OPERAND = N_OPERAND_DEF,
  parameter int N_RESULT  = N_RESULT_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [8*N_OPERAND-1:0] cmd_data,
  input  logic                   cmd_transpose,
  input  logic                   cmd_activation,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [8*N_RESULT-1:0]  res_data,
  output logic                   res_error,
  output logic                   busy,
  output logic [7:0]             tpu_ui_in,
  output logic [7:0]             tpu_uio_in,
  input  logic [7:0]             tpu_uo_out,
  input  logic [7:0]             tpu_uio_out
);

  localparam int IW = $clog2(N_OPERAND);
  localparam int TW = $clog2(TIMEOUT);

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [8*N_OPERAND-1:0] cmd_q, cmd_d;
  logic                   tr_q, tr_d;
  logic                   act_q, act_d;
  logic                   err_q, err_d;
  logic [7:0]             ui_q, ui_d;
  logic [7:0]             uio_q, uio_d;
  logic                   cmd_ready_q;
  logic                   busy_q;
  logic                   res_valid_q;

  logic cap_clr, cap_en, cap_last, cap_short;
  logic done;
  logic unused_uio;

  assign done       = tpu_uio_out[UIO_DONE];
  assign unused_uio = ^tpu_uio_out[6:0];

  tpu_result_capture #(
    .N_RESULT (N_RESULT)
  ) u_cap (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (cap_clr),
    .en_i    (cap_en),
    .done_i  (done),
    .byte_i  (tpu_uo_out),
    .data_o  (res_data),
    .last_o  (cap_last),
    .short_o (cap_short)
  );

  // next-state and registered pin values, aligned with the next state
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    cmd_d   = cmd_q;
    tr_d    = tr_q;
    act_d   = act_q;
    err_d   = err_q;
    ui_d    = ui_q;
    uio_d   = uio_q;
    cap_clr = 1'b0;
    cap_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        uio_d = '0;
        if (cmd_valid && cmd_ready_q) begin
          cmd_d   = cmd_data;
          tr_d    = cmd_transpose;
          act_d   = cmd_activation;
          err_d   = 1'b0;
          cap_clr = 1'b1;
          idx_d   = '0;
          timer_d = '0;
          ui_d    = cmd_data[7:0];
          uio_d[UIO_LOAD_EN]    = 1'b1;
          uio_d[UIO_TRANSPOSE]  = cmd_transpose;
          uio_d[UIO_ACTIVATION] = cmd_activation;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (idx_q == IW'(N_OPERAND - 1)) begin
          ui_d               = '0;
          uio_d[UIO_LOAD_EN] = 1'b0;
          timer_d            = '0;
          state_d            = WAIT;
        end else begin
          idx_d = idx_q + 1'b1;
          ui_d  = cmd_q[8*idx_d +: 8];
        end
      end
      WAIT: begin
        cap_en = 1'b1;
        if (done) begin
          state_d = CAPTURE;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          uio_d   = '0;
          state_d = RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      CAPTURE: begin
        cap_en = 1'b1;
        if (cap_last) begin
          uio_d   = '0;
          state_d = RESP;
        end else if (cap_short) begin
          err_d   = 1'b1;
          uio_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        uio_d = '0;
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        uio_d   = '0;
        ui_d    = '0;
        state_d = IDLE;
      end
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      cmd_q       <= '0;
      tr_q        <= 1'b0;
      act_q       <= 1'b0;
      err_q       <= 1'b0;
      ui_q        <= '0;
      uio_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      cmd_q       <= cmd_d;
      tr_q        <= tr_d;
      act_q       <= act_d;
      err_q       <= err_d;
      ui_q        <= ui_d;
      uio_q       <= uio_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      res_valid_q <= (state_d == RESP);
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = busy_q;
  assign res_valid  = res_valid_q;
  assign res_error  = err_q;
  assign tpu_ui_in  = ui_q;
  assign tpu_uio_in = uio_q;

endmodule

// File: tb/tb_tpu_host_driver.sv
// Self-checking bench for tpu_host_driver.
// Behavioural accelerator model plus per-feature test tasks.
module tb_tpu_host_driver;

  localparam int NOP = 8;
  localparam int NRS = 4;
  localparam int TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [63:0]   cmd_data;
  logic          cmd_transpose;
  logic          cmd_activation;
  logic          res_valid;
  logic          res_ready;
  logic [31:0]   res_data;
  logic          res_error;
  logic          busy;
  logic [7:0]    tpu_ui_in;
  logic [7:0]    tpu_uio_in;
  logic [7:0]    tpu_uo_out;
  logic [7:0]    tpu_uio_out;

  int passed = 0;
  int total  = 0;

  logic [7:0] tr_ui[$];
  logic [7:0] tr_uio[$];
  int last_load;
  int rv_cyc;

  always #5 clk = ~clk;

  tpu_host_driver #(
    .N_OPERAND (NOP),
    .N_RESULT  (NRS),
    .TIMEOUT   (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_data       (cmd_data),
    .cmd_transpose  (cmd_transpose),
    .cmd_activation (cmd_activation),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_error      (res_error),
    .busy           (busy),
    .tpu_ui_in      (tpu_ui_in),
    .tpu_uio_in     (tpu_uio_in),
    .tpu_uo_out     (tpu_uo_out),
    .tpu_uio_out    (tpu_uio_out)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // 2x2 product C = W * X, row-major, low byte of each element
  function automatic logic [31:0] mm(input logic [63:0] d);
    int w[4];
    int x[4];
    int c00, c01, c10, c11;
    for (int k = 0; k < 4; k++) begin
      w[k] = int'(d[8*k +: 8]);
      x[k] = int'(d[32+8*k +: 8]);
    end
    c00 = w[0]*x[0] + w[1]*x[2];
    c01 = w[0]*x[1] + w[1]*x[3];
    c10 = w[2]*x[0] + w[3]*x[2];
    c11 = w[2]*x[1] + w[3]*x[3];
    return {c11[7:0], c10[7:0], c01[7:0], c00[7:0]};
  endfunction

  // expected response given how many bytes the accelerator streams
  function automatic logic [31:0] exp_data(input logic [31:0] s, input int n);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[8*k +: 8] = s[8*k +: 8];
    return r;
  endfunction

  function automatic int exp_lat(input int dl, input int n);
    if (n == 0) return TMO + 1;
    if (n < NRS) return dl + n + 1;
    return dl + NRS;
  endfunction

  task automatic issue(input logic [63:0] d, input bit t, input bit a);
    int w;
    w = 0;
    while (!cmd_ready && w < 20) begin
      cyc();
      w++;
    end
    cmd_data       = d;
    cmd_transpose  = t;
    cmd_activation = a;
    cmd_valid      = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  // accelerator model: done for n cycles starting dl cycles after last load
  task automatic run_job(input int dl, input int n, input logic [31:0] s);
    tr_ui.delete();
    tr_uio.delete();
    last_load = -1;
    rv_cyc    = -1;
    for (int t = 0; t < 200; t++) begin
      tr_ui.push_back(tpu_ui_in);
      tr_uio.push_back(tpu_uio_in);
      if (res_valid) begin
        rv_cyc = t;
        break;
      end
      if (tpu_uio_in[0]) last_load = t;
      if (last_load >= 0 && t - last_load >= dl && t - last_load < dl + n) begin
        tpu_uio_out = {1'b1, 7'($urandom)};
        tpu_uo_out  = s[8*(t-last_load-dl) +: 8];
      end else begin
        tpu_uio_out = {1'b0, 7'($urandom)};
        tpu_uo_out  = 8'($urandom);
      end
      cyc();
    end
    tpu_uio_out = '0;
  endtask

  task automatic finish_resp();
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if ({cmd_ready, res_valid, res_error, busy} !== 4'b1000) begin
      $display("FAIL reset_flags got %b want 1000",
               {cmd_ready, res_valid, res_error, busy});
    end else passed++;
    total++;
    if ({res_data, tpu_ui_in, tpu_uio_in} !== 48'h0) begin
      $display("FAIL reset_data got %h want 0",
               {res_data, tpu_ui_in, tpu_uio_in});
    end else passed++;
  endtask

  task automatic test_basic();
    logic [63:0] d;
    logic [63:0] got;
    int nl;
    d = 64'h0807060501000001;
    issue(d, 1'b0, 1'b0);
    run_job(6, 4, mm(d));
    got = '0;
    nl  = 0;
    foreach (tr_ui[i]) begin
      if (tr_uio[i][0] && nl < NOP) begin
        got[8*nl +: 8] = tr_ui[i];
        nl++;
      end
    end
    total++;
    if (got !== d || last_load != NOP - 1) begin
      $display("FAIL basic_load got %h/%0d want %h/%0d", got, last_load, d, NOP-1);
    end else passed++;
    total++;
    if (rv_cyc - last_load != 10) begin
      $display("FAIL basic_latency got %0d want 10", rv_cyc - last_load);
    end else passed++;
    total++;
    if (res_data !== 32'h08070605 || res_error !== 1'b0) begin
      $display("FAIL basic_result got %h/%b want 08070605/0", res_data, res_error);
    end else passed++;
    finish_resp();
    total++;
    if ({cmd_ready, busy, res_valid} !== 3'b100) begin
      $display("FAIL basic_idle got %b want 100", {cmd_ready, busy, res_valid});
    end else passed++;
  endtask

  task automatic test_flags();
    logic [63:0] d;
    int bad;
    logic [7:0] e;
    d = {$urandom, $urandom};
    issue(d, 1'b1, 1'b1);
    run_job(3, 4, mm(d));
    bad = 0;
    for (int t = 0; t <= rv_cyc; t++) begin
      if (t <= last_load) e = 8'h07;
      else if (t < rv_cyc) e = 8'h06;
      else e = 8'h00;
      if (tr_uio[t] !== e) bad++;
    end
    total++;
    if (bad != 0 || rv_cyc < 0) begin
      $display("FAIL flags_uio got %0d bad cycles (rv %0d) want 0", bad, rv_cyc);
    end else passed++;
    total++;
    if (res_data !== mm(d) || res_error !== 1'b0) begin
      $display("FAIL flags_result got %h/%b want %h/0", res_data, res_error, mm(d));
    end else passed++;
    finish_resp();
  endtask

  task automatic test_timeout();
    issue({$urandom, $urandom}, 1'b0, 1'b1);
    run_job(1, 0, 32'h0);
    total++;
    if (rv_cyc - last_load != TMO + 1) begin
      $display("FAIL timeout_latency got %0d want %0d", rv_cyc - last_load, TMO + 1);
    end else passed++;
    total++;
    if (res_data !== 32'h0 || res_error !== 1'b1) begin
      $display("FAIL timeout_result got %h/%b want 0/1", res_data, res_error);
    end else passed++;
    finish_resp();
  endtask

  task automatic test_short();
    issue({$urandom, $urandom}, 1'b0, 1'b0);
    run_job(4, 2, 32'h1234BBAA);
    total++;
    if (res_data !== 32'h0000BBAA || res_error !== 1'b1) begin
      $display("FAIL short_result got %h/%b want 0000bbaa/1", res_data, res_error);
    end else passed++;
    total++;
    if (rv_cyc - last_load != 7) begin
      $display("FAIL short_latency got %0d want 7", rv_cyc - last_load);
    end else passed++;
    finish_resp();
  endtask

  task automatic test_back_to_back();
    logic [63:0] d1, d2;
    int bad;
    d1 = {$urandom, $urandom};
    d2 = {$urandom, $urandom};
    issue(d1, 1'b0, 1'b0);
    run_job(2, 4, mm(d1));
    cmd_data  = d2;
    cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (res_valid !== 1'b1 || res_data !== mm(d1) || cmd_ready !== 1'b0) bad++;
      cyc();
    end
    total++;
    if (bad != 0) begin
      $display("FAIL bp_stable got %0d bad cycles want 0", bad);
    end else passed++;
    res_ready = 1'b1;
    cyc();
    res_ready = 1'b0;
    total++;
    if ({cmd_ready, res_valid, tpu_uio_in} !== 10'b10_0000_0000) begin
      $display("FAIL b2b_idle got %b want 1000000000",
               {cmd_ready, res_valid, tpu_uio_in});
    end else passed++;
    cyc();
    cmd_valid = 1'b0;
    total++;
    if (tpu_uio_in[0] !== 1'b1 || tpu_ui_in !== d2[7:0]) begin
      $display("FAIL b2b_first got %b/%h want 1/%h", tpu_uio_in[0], tpu_ui_in, d2[7:0]);
    end else passed++;
    run_job(5, 4, mm(d2));
    total++;
    if (res_data !== mm(d2) || res_error !== 1'b0) begin
      $display("FAIL b2b_result got %h/%b want %h/0", res_data, res_error, mm(d2));
    end else passed++;
    finish_resp();
  endtask

  task automatic test_reset_mid_load();
    logic [63:0] d;
    d = {$urandom, $urandom};
    issue(d, 1'b1, 1'b0);
    cyc();
    cyc();
    cyc();
    total++;
    if (tpu_ui_in !== d[31:24] || tpu_uio_in !== 8'h03) begin
      $display("FAIL midload_idx3 got %h/%h want %h/03", tpu_ui_in, tpu_uio_in, d[31:24]);
    end else passed++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++;
    if ({tpu_uio_in, tpu_ui_in, busy, cmd_ready} !== 18'b01) begin
      $display("FAIL midload_reset got %h/%h/%b/%b want 00/00/0/1",
               tpu_uio_in, tpu_ui_in, busy, cmd_ready);
    end else passed++;
    d = {$urandom, $urandom};
    issue(d, 1'b0, 1'b1);
    run_job(3, 4, mm(d));
    total++;
    if (res_data !== mm(d) || res_error !== 1'b0 || rv_cyc - last_load != 7) begin
      $display("FAIL midload_next got %h/%b/%0d want %h/0/7",
               res_data, res_error, rv_cyc - last_load, mm(d));
    end else passed++;
    finish_resp();
  endtask

  task automatic test_random();
    logic [63:0] d;
    logic [63:0] got;
    logic [31:0] s;
    int dl, n, sel, nl;
    for (int j = 0; j < 8; j++) begin
      d   = {$urandom, $urandom};
      s   = mm(d);
      dl  = $urandom_range(1, 12);
      sel = $urandom_range(0, 6);
      n   = (sel >= NRS) ? NRS : sel;
      issue(d, 1'($urandom), 1'($urandom));
      run_job(dl, n, s);
      got = '0;
      nl  = 0;
      foreach (tr_ui[i]) begin
        if (tr_uio[i][0] && nl < NOP) begin
          got[8*nl +: 8] = tr_ui[i];
          nl++;
        end
      end
      total++;
      if (got !== d || nl != NOP) begin
        $display("FAIL rand_load[%0d] got %h want %h", j, got, d);
      end else passed++;
      total++;
      if (res_data !== exp_data(s, n) || res_error !== (n < NRS)
          || rv_cyc - last_load != exp_lat(dl, n)) begin
        $display("FAIL rand_job[%0d] got %h/%b/%0d want %h/%b/%0d", j,
                 res_data, res_error, rv_cyc - last_load,
                 exp_data(s, n), (n < NRS), exp_lat(dl, n));
      end else passed++;
      finish_resp();
    end
  endtask

  initial begin
    rst            = 1'b1;
    cmd_valid      = 1'b0;
    cmd_data       = '0;
    cmd_transpose  = 1'b0;
    cmd_activation = 1'b0;
    res_ready      = 1'b0;
    tpu_uo_out     = '0;
    tpu_uio_out    = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
    test_reset();
    test_basic();
    test_flags();
    test_short();
    test_timeout();
    test_back_to_back();
    test_reset_mid_load();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tpu_host_driver.md
Name: tpu_host_driver

Overview:
- Host-side initiator for the 2x2 matrix-multiply accelerator pin interface.
- Accepts one job per command: 8 operand bytes plus the transpose and activation flags, through a valid/ready port.
- Drives the accelerator's byte-load protocol, waits for done, captures the 4 result bytes, and returns them through a valid/ready response port.
- Sits in the host/FPGA test harness or SoC wrapper, directly on the accelerator's ui_in, uio_in, uo_out and uio_out pins.

Parameters:
- N_OPERAND, 8, operand bytes per job: weight0..3, then input0..3.
- N_RESULT, 4, result bytes per job: c00, c01, c10, c11, low byte of each.
- TIMEOUT, 64, maximum WAIT cycles for done before the job is aborted.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  job offered.
- cmd_ready  out  1  driver can accept a job.
- cmd_data  in  8*N_OPERAND  operand bytes; byte k = bits [8k+7:8k], sent in order k = 0, 1, 2 and so on.
- cmd_transpose  in  1  transpose flag for the job.
- cmd_activation  in  1  activation flag for the job.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  8*N_RESULT  captured bytes; first captured byte in [7:0].
- res_error  out  1  timeout or short result burst.
- busy  out  1  state is not IDLE.
- tpu_ui_in  out  8  accelerator data input.
- tpu_uio_in  out  8  [0] load_en, [1] transpose, [2] activation, [7:3] = 0.
- tpu_uo_out  in  8  accelerator result byte.
- tpu_uio_out  in  8  [7] done; [6:5] state, ignored; [4:0] ignored.

Behaviour:
- Reset (rst = 1 at a clk edge) forces the following on that edge, including from any state mid-job:
  - state = IDLE;
  - cmd_ready = 1, res_valid = 0, res_error = 0, busy = 0;
  - res_data = 0, tpu_ui_in = 0, tpu_uio_in = 0;
  - all counters = 0.
- All outputs are registered.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch cmd_data and both flags, clear res_data and res_error, set idx = 0, go to LOAD.
- LOAD, exactly N_OPERAND cycles:
  - Each cycle drive tpu_ui_in = byte[idx], uio_in[0] = 1, uio_in[1] = latched transpose, uio_in[2] = latched activation.
  - idx increments each cycle.
  - After byte N_OPERAND-1, go to WAIT with load_en = 0 on the next cycle.
  - No gap cycles are allowed between bytes.
- WAIT:
  - load_en = 0; transpose and activation stay driven.
  - timer increments every cycle.
  - If tpu_uio_out[7] = 1: capture tpu_uo_out into res_data byte 0, set ridx = 1, go to CAPTURE.
  - Else if timer = TIMEOUT-1: set res_error = 1, go to RESP with res_data = 0.
- CAPTURE:
  - Each cycle with done = 1: store tpu_uo_out into byte ridx, then ridx increments.
  - After byte N_RESULT-1 is stored, go to RESP.
  - If done = 0 before all bytes are captured: set res_error = 1, go to RESP, keeping the partial bytes.
- RESP:
  - res_valid = 1; res_data and res_error are held stable while res_ready = 0.
  - On res_valid & res_ready: go to IDLE, res_valid = 0.
- tpu_uio_in returns to 0 in RESP and IDLE.
- cmd_ready = 0 in every state except IDLE; a new command is only accepted the cycle after a response handshake.
- Latency with done arriving D cycles after the last load byte: cmd accept, then N_OPERAND load cycles, then D wait cycles, then N_RESULT capture cycles, then res_valid.
- Counter widths: idx is clog2(N_OPERAND) bits; ridx is clog2(N_RESULT) bits; timer is clog2(TIMEOUT) bits. No counter wraps, because every state exits before overflow.

Decomposition:
- Shared package tpu_host_pkg holds:
  - state enum IDLE, LOAD, WAIT, CAPTURE, RESP;
  - bit-index constants UIO_LOAD_EN = 0, UIO_TRANSPOSE = 1, UIO_ACTIVATION = 2, UIO_DONE = 7;
  - the parameter defaults.
- One natural sub-module, tpu_result_capture: ridx counter, byte shift-in and short-burst detection, under the parent FSM's enable.

Test Plan:
- Basic job:
  - Stimulus: cmd_data = 0x0807060501000001 (weights 1,0,0,1; inputs 5,6,7,8), no flags. Bench model asserts done 6 cycles after the last load and streams 05, 06, 07, 08.
  - Required: ui_in sequence 01, 00, 00, 01, 05, 06, 07, 08 with load_en high for exactly 8 cycles; then res_data = 0x08070605, res_error = 0.
- Flags:
  - Stimulus: cmd_transpose = 1, cmd_activation = 1.
  - Required: tpu_uio_in = 0x07 during LOAD, 0x06 during WAIT and CAPTURE, 0x00 in RESP.
- Timeout:
  - Stimulus: bench never asserts done.
  - Required: res_valid rises exactly TIMEOUT cycles after WAIT entry, with res_error = 1 and res_data = 0.
- Short burst:
  - Stimulus: done high for 2 cycles only, carrying AA then BB.
  - Required: res_data = 0x0000BBAA, res_error = 1.
- Backpressure and back-to-back:
  - Stimulus: res_ready held low 5 cycles; a second cmd_valid is held throughout.
  - Required: res_data stable and cmd_ready = 0 the whole time. The second job's first load byte appears 2 cycles after the response handshake: one cycle IDLE accept, then LOAD.
- Reset mid-LOAD:
  - Stimulus: rst pulsed at idx = 3.
  - Required: next cycle tpu_uio_in = 0, tpu_ui_in = 0, busy = 0, cmd_ready = 1. A following job completes normally.
